pam_demap_deframe: RTL
======================

// Module: pam_demap_deframe
// PURPOSE
//  Receive-side counterpart of the PAM transmit chain (AXI-Stream -> PAM map -> frame head -> DAC).
//  Takes ADC samples and hunts for the frame head pattern.
//  After a head is found, slices the payload samples into PAM symbols and packs them MSB-first into DATA_WIDTH words.
//  Delivers the words on an AXI-Stream master through a small output FIFO, with tlast on the last word of each frame.
// PARAMETERS
//  DATA_WIDTH     32         output word width; must be a multiple of BPS=log2(PAM_ORDER)
//  PAM_ORDER      4          PAM levels (2,4,8,16); BPS = log2(PAM_ORDER) bits per symbol
//  AD_CVER_WIDTH  12         ADC sample width, unsigned offset-binary
//  HEAD_LEN       16         frame head length in samples
//  HEAD_PATTERN   16'hF0A5   head bits, MSB sent first; 1 = full-scale high, 0 = zero level
//  FRAME_WORDS    256        payload words per frame (>=1)
//  FIFO_DEPTH     4          output FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1              system clock
//  arst           in   1              asynchronous reset, active-high
//  ad_data        in   AD_CVER_WIDTH  ADC sample
//  ad_valid       in   1              ad_data valid this cycle; cannot be back-pressured
//  S_AXIS_tdata   out  DATA_WIDTH     packed payload word
//  S_AXIS_tlast   out  1              last word of the frame
//  S_AXIS_tkeep   out  DATA_WIDTH/8   constant all ones
//  S_AXIS_tvalid  out  1              word available
//  S_AXIS_tready  in   1              downstream accepts the word
//  frame_lock     out  1              high while in the PAYLOAD state
//  overflow       out  1              sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=HUNT; head shift register, symbol counter, word counter and FIFO are cleared.
//   - Outputs: tvalid=0, tdata=0, tlast=0, frame_lock=0, overflow=0.
//  Slicer: sym = ad_data[AD_CVER_WIDTH-1 -: BPS] (uniform thresholds, natural binary); head bit = ad_data MSB.
//   - Only cycles with ad_valid=1 have any effect; ad_valid=0 cycles are ignored in every state.
//  HUNT:
//   - Shift the head bit into the HEAD_LEN-bit register, new bit at the LSB.
//   - If the register value after this shift equals HEAD_PATTERN, go to PAYLOAD on the next cycle.
//   - The first payload sample is the next valid sample after the last head sample.
//  PAYLOAD:
//   - Shift sym into the word accumulator: acc = {acc, sym}, so the first symbol ends up in the MSBs.
//   - Every DATA_WIDTH/BPS symbols, push {acc, last} into the FIFO, with last=1 on word FRAME_WORDS-1.
//   - After the push of the last word: go to HUNT, clear the head register, reset the counters.
//   - There is no head search while in PAYLOAD.
//  Latency: with the FIFO empty, tvalid rises 2 clk after the ad_valid cycle that carries the word's final symbol.
//  FIFO / handshake:
//   - Word transfers when tvalid & tready.
//   - tdata and tlast are held stable while tvalid=1 & tready=0.
//   - tvalid never drops without a transfer.
//   - A push and a pop in the same cycle on a full FIFO both happen; no drop.
//   - A push when full and no pop in that cycle: the word is discarded and overflow is set (cleared only by arst).
//   - Counting continues after a drop, so frame alignment is kept.
//   - If the dropped word is the tlast word, the frame is delivered without tlast.
//  Boundaries:
//   - Head bits that straddle a HUNT re-entry start fresh, because the head register is cleared.
//   - Back-to-back frames with no idle samples are detected.
//   - arst mid-frame: the partial accumulator and all FIFO contents are lost; the block restarts in HUNT.
// TESTING
//  Use BPS=2, SYM_PER_WORD=16, FRAME_WORDS=2 unless noted; symbol k is sent as ad_data={k,10'h200}.
//  1. Head 0xF0A5 (1->0xFFF, 0->0x000), then 32 symbols 0,1,2,3 repeating, tready=1
//     -> words 0x1B1B1B1B (tlast=0) and 0x1B1B1B1B (tlast=1); frame_lock falls after the push of the last word.
//  2. Random samples with no head, 10k cycles
//     -> tvalid stays 0 and frame_lock stays 0.
//  3. Head, then a payload with ad_valid toggled randomly at 50%
//     -> same words as test 1; gaps have no effect.
//  4. tready=0 while 6 words arrive (FRAME_WORDS=6, FIFO_DEPTH=4)
//     -> words 0-3 are held and words 4-5 are dropped; overflow=1; after tready=1, exactly 4 words come out, in order.
//  5. Two frames back-to-back, no gap
//     -> 4 words out with tlast on words 1 and 3.
//  6. Assert arst mid-payload, then send a new full frame
//     -> all outputs 0 during reset; afterwards only the new frame's 2 words appear.

Source files
------------

// File: rtl/pam_demap_deframe.sv
// PAM receive path: hunts for the frame head in the ADC stream, slices the payload
// into symbols, packs them MSB-first and delivers words on an AXI-Stream master via a small FIFO.
module pam_demap_deframe #(
    parameter int                DATA_WIDTH    = 32,
    parameter int                PAM_ORDER     = 4,
    parameter int                AD_CVER_WIDTH = 12,
    parameter int                HEAD_LEN      = 16,
    parameter logic [HEAD_LEN-1:0] HEAD_PATTERN = 16'hF0A5,
    parameter int                FRAME_WORDS   = 256,
    parameter int                FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [AD_CVER_WIDTH-1:0] ad_data,
    input  logic                     ad_valid,
    output logic [DATA_WIDTH-1:0]    S_AXIS_tdata,
    output logic                     S_AXIS_tlast,
    output logic [DATA_WIDTH/8-1:0]  S_AXIS_tkeep,
    output logic                     S_AXIS_tvalid,
    input  logic                     S_AXIS_tready,
    output logic                     frame_lock,
    output logic                     overflow
);
    localparam int BPS = $clog2(PAM_ORDER);
    localparam int SPW = DATA_WIDTH / BPS;
    localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {HUNT, PAYLOAD} state_t;

    // Reset asserts immediately, releases on a clock edge
    logic [1:0] rst_sr;
    logic       rst;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) rst_sr <= 2'b11;
        else      rst_sr <= {rst_sr[0], 1'b0};
    end
    assign rst = rst_sr[1];

    state_t                  state, state_nxt;
    logic [HEAD_LEN-1:0]     head_sr, head_nxt, head_shift;
    logic [DATA_WIDTH-1:0]   acc, acc_nxt, acc_shift;
    logic [SCW-1:0]          sym_cnt, sym_nxt;
    logic [WCW-1:0]          word_cnt, word_nxt;
    logic [BPS-1:0]          sym;
    logic                    push, push_last;
    logic                    wr_vld, wr_last;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    unused_bits;

    assign sym         = ad_data[AD_CVER_WIDTH-1 -: BPS];
    assign head_shift  = (head_sr << 1) | HEAD_LEN'(ad_data[AD_CVER_WIDTH-1]);
    assign acc_shift   = (acc << BPS) | DATA_WIDTH'(sym);
    assign unused_bits = ^ad_data[AD_CVER_WIDTH-BPS-1:0];

    always_comb begin
        state_nxt = state;
        head_nxt  = head_sr;
        acc_nxt   = acc;
        sym_nxt   = sym_cnt;
        word_nxt  = word_cnt;
        push      = 1'b0;
        push_last = 1'b0;
        if (ad_valid) begin
            case (state)
                HUNT: begin
                    head_nxt = head_shift;
                    if (head_shift == HEAD_PATTERN) state_nxt = PAYLOAD;
                end
                PAYLOAD: begin
                    acc_nxt = acc_shift;
                    sym_nxt = sym_cnt + 1'b1;
                    if (sym_cnt == SCW'(SPW - 1)) begin
                        sym_nxt  = '0;
                        push     = 1'b1;
                        word_nxt = word_cnt + 1'b1;
                        if (word_cnt == WCW'(FRAME_WORDS - 1)) begin
                            // Clearing the head register makes the next hunt start fresh
                            push_last = 1'b1;
                            word_nxt  = '0;
                            head_nxt  = '0;
                            state_nxt = HUNT;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            head_sr  <= '0;
            acc      <= '0;
            sym_cnt  <= '0;
            word_cnt <= '0;
            wr_vld   <= 1'b0;
            wr_last  <= 1'b0;
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            head_sr  <= head_nxt;
            acc      <= acc_nxt;
            sym_cnt  <= sym_nxt;
            word_cnt <= word_nxt;
            wr_vld   <= push;
            wr_last  <= push_last;
            wr_data  <= acc_shift;
        end
    end

    // Output FIFO
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  full, pop, wr_ok;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = S_AXIS_tvalid & S_AXIS_tready;
    assign wr_ok = wr_vld & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
            if (wr_vld && !wr_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_data[wr_ptr] <= wr_data;
            mem_last[wr_ptr] <= wr_last;
        end
    end

    assign S_AXIS_tvalid = (count != '0);
    assign S_AXIS_tdata  = S_AXIS_tvalid ? mem_data[rd_ptr] : '0;
    assign S_AXIS_tlast  = S_AXIS_tvalid ? mem_last[rd_ptr] : 1'b0;
    assign S_AXIS_tkeep  = '1;
    assign frame_lock    = (state == PAYLOAD);
endmodule
